// File: rtl/accum_operand_seq.sv
// rtl/accum_operand_seq.sv - FIFO-buffered burst operand sequencer feeding accum_nbits
// Optional feature: ACCUM_SEQ_BYPASS_EN (empty-FIFO push goes straight to acc_x_o).
`timescale 1ns/1ps
module accum_operand_seq #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = 8
) (
    input  logic                           clk_i,
    input  logic                           nrst_i,
    input  logic                           s_valid_i,
    input  logic [WIDTH-1:0]               s_data_i,
    output logic                           s_ready_o,
    output logic [WIDTH-1:0]               acc_x_o,
    output logic                           acc_clr_o,
    output logic                           burst_done_o,
    output logic [$clog2(BURST_LEN+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {RUN, DONE, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_x, acc_x_nxt;
    logic             full, empty, push, push_fifo, pop, issue;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = s_valid_i && !full;

    always_comb begin
        state_nxt = state;
        acc_x_nxt = '0;
        pop       = 1'b0;
        issue     = 1'b0;
        push_fifo = push;
        case (state)
            RUN: begin
                if (!empty) begin
                    pop       = 1'b1;
                    issue     = 1'b1;
                    acc_x_nxt = mem[rd_ptr[AW-1:0]];
                end
`ifdef ACCUM_SEQ_BYPASS_EN
                else if (push) begin
                    push_fifo = 1'b0;
                    issue     = 1'b1;
                    acc_x_nxt = s_data_i;
                end
`endif
                if (issue && (count == LAST_CNT)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_fifo) begin
            mem[wr_ptr[AW-1:0]] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state  <= RUN;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            acc_x  <= '0;
        end else begin
            state <= state_nxt;
            acc_x <= acc_x_nxt;
            if (push_fifo) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (issue) begin
                count <= (count == LAST_CNT) ? '0 : count + CW'(1);
            end
        end
    end

    assign s_ready_o    = !full;
    assign acc_x_o      = acc_x;
    assign burst_done_o = (state == DONE);
    assign acc_clr_o    = (state == CLEAR);
    assign count_o      = count;
endmodule

// File: tb/tb_accum_operand_seq.sv
// tb/tb_accum_operand_seq.sv - self-checking bench for accum_operand_seq (three parameter sets)
`timescale 1ns/1ps
module tb_accum_operand_seq;
    localparam int W  = 32;
    localparam int NI = 3;
`ifdef ACCUM_SEQ_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         nrst;
    logic         v   [NI];
    logic [W-1:0] d   [NI];
    logic         rdy [NI];
    logic [W-1:0] x   [NI];
    logic         clr [NI];
    logic         done[NI];
    logic [3:0]   cnt_a, cnt_b;
    logic [0:0]   cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    accum_operand_seq #(.WIDTH(W), .DEPTH(4), .BURST_LEN(8)) u_a (
        .clk_i(clk), .nrst_i(nrst), .s_valid_i(v[0]), .s_data_i(d[0]), .s_ready_o(rdy[0]),
        .acc_x_o(x[0]), .acc_clr_o(clr[0]), .burst_done_o(done[0]), .count_o(cnt_a));
    accum_operand_seq #(.WIDTH(W), .DEPTH(2), .BURST_LEN(8)) u_b (
        .clk_i(clk), .nrst_i(nrst), .s_valid_i(v[1]), .s_data_i(d[1]), .s_ready_o(rdy[1]),
        .acc_x_o(x[1]), .acc_clr_o(clr[1]), .burst_done_o(done[1]), .count_o(cnt_b));
    accum_operand_seq #(.WIDTH(W), .DEPTH(4), .BURST_LEN(1)) u_c (
        .clk_i(clk), .nrst_i(nrst), .s_valid_i(v[2]), .s_data_i(d[2]), .s_ready_o(rdy[2]),
        .acc_x_o(x[2]), .acc_clr_o(clr[2]), .burst_done_o(done[2]), .count_o(cnt_c));

    function automatic int depth_of(input int i);
        return (i == 1) ? 2 : 4;
    endfunction

    function automatic int blen_of(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic logic [63:0] cnt_of(input int i);
        case (i)
            0:       return 64'(cnt_a);
            1:       return 64'(cnt_b);
            default: return 64'(cnt_c);
        endcase
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endtask

    // Model: operand queue, issued count and burst phase (0 run, 1 done, 2 clear)
    logic [W-1:0] mq [NI][8];
    int           mh  [NI];
    int           ms  [NI];
    int           mcnt[NI];
    int           mph [NI];
    logic [W-1:0] mx  [NI];

    task automatic model_step(input int i);
        bit push, issued;
        push   = v[i] && (ms[i] < depth_of(i));
        issued = 1'b0;
        mx[i]  = '0;
        if (mph[i] == 0) begin
            if (ms[i] > 0) begin
                mx[i] = mq[i][mh[i]];
                mh[i] = (mh[i] + 1) % 8;
                ms[i] = ms[i] - 1;
                issued = 1'b1;
            end else if (BYP && push) begin
                mx[i]  = d[i];
                push   = 1'b0;
                issued = 1'b1;
            end
            if (issued) begin
                mcnt[i] = mcnt[i] + 1;
                if (mcnt[i] == blen_of(i)) begin
                    mcnt[i] = 0;
                    mph[i]  = 1;
                end
            end
        end else begin
            mph[i] = (mph[i] == 1) ? 2 : 0;
        end
        if (push) begin
            mq[i][(mh[i] + ms[i]) % 8] = d[i];
            ms[i] = ms[i] + 1;
        end
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NI; i++) begin
                mh[i] = 0; ms[i] = 0; mcnt[i] = 0; mph[i] = 0; mx[i] = '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) model_step(i);
        end
    end

    // Expected burst sums, hand-computed per test
    int           es0[$], es1[$], es2[$];
    logic [63:0]  run_sum[NI];

    task automatic take_sum(input int i, output bit ok, output int s);
        ok = 1'b0;
        s  = 0;
        case (i)
            0: if (es0.size() > 0) begin s = es0.pop_front(); ok = 1'b1; end
            1: if (es1.size() > 0) begin s = es1.pop_front(); ok = 1'b1; end
            default: if (es2.size() > 0) begin s = es2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    always @(negedge clk) begin
        bit ok;
        int s;
        if (!nrst) begin
            for (int i = 0; i < NI; i++) run_sum[i] = '0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                check("ready", i, 64'(rdy[i]), 64'(ms[i] < depth_of(i)));
                check("acc_x", i, 64'(x[i]), 64'(mx[i]));
                check("done", i, 64'(done[i]), 64'(mph[i] == 1));
                check("clr", i, 64'(clr[i]), 64'(mph[i] == 2));
                check("count", i, cnt_of(i), 64'(mcnt[i]));
                if (clr[i]) begin
                    take_sum(i, ok, s);
                    check("sum_expected", i, 64'(ok), 64'(1));
                    if (ok) check("burst_sum", i, run_sum[i], 64'(s));
                    run_sum[i] = '0;
                end else begin
                    run_sum[i] = run_sum[i] + 64'(x[i]);
                end
            end
        end
    end

    initial begin
        int t3[12];
        int nxt, low_seen;
        bit prev_rdy;
        nrst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_ready", 0, 64'(rdy[0]), 64'(1));
        check("rst_x", 0, 64'(x[0]), 64'(0));
        check("rst_count", 0, 64'(cnt_a), 64'(0));
        nrst = 1'b1;

        // Back-to-back 1..13: first burst 1..8, then reset mid-way through the next
        es0.push_back(36);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 13) begin v[0] = 1'b1; d[0] = W'(k); end
            else v[0] = 1'b0;
            if (k <= 8 + LAT) check("t2_x", k, 64'(x[0]), (k > LAT) ? 64'(k - LAT) : 64'(0));
            if (k == 8 + LAT) begin
                check("t2_done", k, 64'(done[0]), 64'(1));
                check("t2_count_wrap", k, 64'(cnt_a), 64'(0));
            end
            if (k == 9 + LAT) begin
                check("t2_clr", k, 64'(clr[0]), 64'(1));
                check("t2_clr_x", k, 64'(x[0]), 64'(0));
            end
        end
        check("t1_midburst", 0, 64'(cnt_a != 0), 64'(1));
        #2 nrst = 1'b0;
        #1;
        check("t1_async_x", 0, 64'(x[0]), 64'(0));
        check("t1_async_count", 0, 64'(cnt_a), 64'(0));
        check("t1_async_done", 0, 64'(done[0]), 64'(0));
        check("t1_async_clr", 0, 64'(clr[0]), 64'(0));
        check("t1_async_ready", 0, 64'(rdy[0]), 64'(1));
        repeat (2) @(negedge clk);
        check("t1_rst_ready", 1, 64'(rdy[0]), 64'(1));
        nrst = 1'b1;
        @(negedge clk);

        // Gap of three idle cycles after operand 4
        t3 = '{1, 2, 3, 4, 0, 0, 0, 5, 6, 7, 8, 0};
        es0.push_back(36);
        for (int k = 0; k < 16; k++) begin
            int e;
            @(negedge clk);
            if (k < 12 && t3[k] != 0) begin v[0] = 1'b1; d[0] = W'(t3[k]); end
            else v[0] = 1'b0;
            e = 0;
            if (k >= LAT && k - LAT < 12) e = t3[k - LAT];
            check("t3_x", k, 64'(x[0]), 64'(e));
            if (k == LAT) check("t3_first_count", k, 64'(cnt_a), 64'(1));
            if (k - LAT >= 4 && k - LAT <= 6) check("t3_hold_count", k, 64'(cnt_a), 64'(4));
            if (k == 10 + LAT) check("t3_done", k, 64'(done[0]), 64'(1));
        end

        // DEPTH=2, continuous valid over three bursts of 1..24
        es1.push_back(36);
        es1.push_back(100);
        es1.push_back(164);
        nxt = 1;
        prev_rdy = 1'b0;
        low_seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (v[1] && prev_rdy) nxt++;
            if (nxt <= 24) begin v[1] = 1'b1; d[1] = W'(nxt); end
            else v[1] = 1'b0;
            prev_rdy = rdy[1];
            if (!rdy[1]) low_seen++;
        end
        check("t4_all_pushed", 1, 64'(nxt), 64'(25));
        check("t4_ready_dropped", 1, 64'(low_seen > 0), 64'(1));

        // BURST_LEN=1: 5 then 7 back-to-back
        es2.push_back(5);
        es2.push_back(7);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            v[2] = (k < 2);
            d[2] = (k == 0) ? W'(5) : W'(7);
            if (k == LAT) begin
                check("t5_x5", k, 64'(x[2]), 64'(5));
                check("t5_done5", k, 64'(done[2]), 64'(1));
            end
            if (k == LAT + 1) check("t5_clr5", k, 64'(clr[2]), 64'(1));
            if (k == LAT + 3) begin
                check("t5_x7", k, 64'(x[2]), 64'(7));
                check("t5_done7", k, 64'(done[2]), 64'(1));
            end
            if (k == LAT + 4) check("t5_clr7", k, 64'(clr[2]), 64'(1));
        end

        // Latency of a single operand into an empty FIFO
        es2.push_back(9);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            v[2] = (k == 0);
            d[2] = W'(9);
            if (k == 1) check("t6_x_k1", k, 64'(x[2]), BYP ? 64'(9) : 64'(0));
            if (k == 2) check("t6_x_k2", k, 64'(x[2]), BYP ? 64'(0) : 64'(9));
            if (k == LAT) check("t6_done", k, 64'(done[2]), 64'(1));
        end

        repeat (3) @(negedge clk);
        check("sums_left", 0, 64'(es0.size()), 64'(0));
        check("sums_left", 1, 64'(es1.size()), 64'(0));
        check("sums_left", 2, 64'(es2.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
